// File: rtl/fp_mul_pkg.sv
// Shared constants and beat types for the binary32 multiplier back end.
package fp_mul_pkg;

    localparam int MANT_W   = 23;
    localparam int PROD_W   = 48;
    localparam int EXPSUM_W = 9;
    localparam int EXP_W    = 10;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'b00,
        CLS_ZERO   = 2'b01,
        CLS_INF    = 2'b10,
        CLS_NAN    = 2'b11
    } fp_class_e;

    // Normalised beat between stage 1 and stage 2; e is two's complement.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] keep;
        logic              guard;
        logic              sticky;
        logic              is_nan;
        logic              is_inf;
        logic              is_zero;
    } s1_beat_t;

    typedef struct packed {
        logic [31:0] result;
        logic        overflow;
        logic        underflow;
        logic        exception;
    } s2_beat_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised 23-bit fraction; purely combinational.
module fp_round_rne
    import fp_mul_pkg::*;
(
    input  logic [MANT_W-1:0] keep,
    input  logic              guard,
    input  logic              sticky,
    input  logic [EXP_W-1:0]  e,
    input  logic              round_en,
    output logic [MANT_W-1:0] mant,
    output logic [EXP_W-1:0]  e_adj,
    output logic              carry
);

    logic inc;

    assign inc = round_en & guard & (sticky | keep[0]);

    // An all-ones fraction wraps to zero, which is exactly the renormalised mantissa.
    assign {carry, mant} = {1'b0, keep} + {{MANT_W{1'b0}}, inc};
    assign e_adj         = e + {{(EXP_W-1){1'b0}}, carry};

endmodule

// File: rtl/fp_mul_round_stage.sv
// Two-stage normalise / round / pack back end of the binary32 multiplier,
// with valid/ready flow control so writeback can stall the pipe.
module fp_mul_round_stage
    import fp_mul_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int EXP_BIAS = fp_mul_pkg::EXP_BIAS,
    parameter bit ROUND_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_sign,
    input  logic [EXPSUM_W-1:0] in_exp_sum,
    input  logic [PROD_W-1:0]   in_mant_prod,
    input  logic [1:0]          in_a_class,
    input  logic [1:0]          in_b_class,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     result,
    output logic                overflow,
    output logic                underflow,
    output logic                exception
);

    localparam logic [EXP_W-1:0] BIAS_V = EXP_W'(EXP_BIAS);
    localparam logic [EXP_W-1:0] EMAX_V = EXP_W'(EXP_MAX);

    logic [2:1]        vld_pipe;
    logic              s1_adv, s2_adv;
    logic              norm;
    s1_beat_t          s1_d, s1_q;
    s2_beat_t          s2_d, s2_q;
    logic [MANT_W-1:0] mant_r;
    logic [EXP_W-1:0]  e_adj;
    logic              carry;
    logic              e_le0, e_ovf;

    assign s2_adv   = ~vld_pipe[2] | out_ready;
    assign s1_adv   = ~vld_pipe[1] | s2_adv;
    assign in_ready = s1_adv;

    // Stage 1: align on the product's leading one and split off guard/sticky.
    always_comb begin
        s1_d      = '0;
        norm      = in_mant_prod[PROD_W-1];
        s1_d.sign = in_sign;
        if (norm) begin
            s1_d.keep   = in_mant_prod[46:24];
            s1_d.guard  = in_mant_prod[23];
            s1_d.sticky = |in_mant_prod[22:0];
        end else begin
            s1_d.keep   = in_mant_prod[45:23];
            s1_d.guard  = in_mant_prod[22];
            s1_d.sticky = |in_mant_prod[21:0];
        end
        s1_d.e       = {1'b0, in_exp_sum} - BIAS_V + {{(EXP_W-1){1'b0}}, norm};
        s1_d.is_nan  = (in_a_class == CLS_NAN) || (in_b_class == CLS_NAN) ||
                       (in_a_class == CLS_INF  && in_b_class == CLS_ZERO) ||
                       (in_a_class == CLS_ZERO && in_b_class == CLS_INF);
        s1_d.is_inf  = (in_a_class == CLS_INF)  || (in_b_class == CLS_INF);
        s1_d.is_zero = (in_a_class == CLS_ZERO) || (in_b_class == CLS_ZERO);
    end

    fp_round_rne u_round (
        .keep     (s1_q.keep),
        .guard    (s1_q.guard),
        .sticky   (s1_q.sticky),
        .e        (s1_q.e),
        .round_en (ROUND_EN),
        .mant     (mant_r),
        .e_adj    (e_adj),
        .carry    (carry)
    );

    // Underflow looks at the pre-round exponent; overflow is only evaluated once e > 0.
    assign e_le0 = s1_q.e[EXP_W-1] | (s1_q.e == '0);
    assign e_ovf = (s1_q.e >= EMAX_V) | (carry & (s1_q.e == EMAX_V - 1'b1));

    // Stage 2: special-case priority, then pack. Empty slots carry all-zero flags.
    always_comb begin
        s2_d = '0;
        if (s1_q.is_nan) begin
            s2_d.result    = QNAN;
            s2_d.exception = 1'b1;
        end else if (s1_q.is_inf) begin
            s2_d.result = {s1_q.sign, 8'hFF, 23'h0};
        end else if (s1_q.is_zero) begin
            s2_d.result = {s1_q.sign, 31'h0};
        end else if (e_le0) begin
            s2_d.result    = {s1_q.sign, 31'h0};
            s2_d.underflow = 1'b1;
        end else if (e_ovf) begin
            s2_d.result   = {s1_q.sign, 8'hFF, 23'h0};
            s2_d.overflow = 1'b1;
        end else begin
            s2_d.result = {s1_q.sign, e_adj[7:0], mant_r};
        end
        if (!vld_pipe[1]) s2_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid;
                s1_q        <= s1_d;
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                s2_q        <= s2_d;
            end
        end
    end

    assign out_valid = vld_pipe[2];
    assign result    = s2_q.result;
    assign overflow  = s2_q.overflow;
    assign underflow = s2_q.underflow;
    assign exception = s2_q.exception;

endmodule

// File: tb/tb_fp_mul_round_stage.sv
// Bench for fp_mul_round_stage: directed table, backpressure, reset and random scoreboard.
module tb_fp_mul_round_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_sign, out_ready;
    logic [8:0]  in_exp_sum;
    logic [47:0] in_mant_prod;
    logic [1:0]  in_a_class, in_b_class;

    logic        in_ready, out_valid, overflow, underflow, exception;
    logic [31:0] result;
    logic        in_ready_t, out_valid_t, overflow_t, underflow_t, exception_t;
    logic [31:0] result_t;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_mul_round_stage #(.XLEN(32), .EXP_BIAS(127), .ROUND_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp_sum(in_exp_sum), .in_mant_prod(in_mant_prod),
        .in_a_class(in_a_class), .in_b_class(in_b_class),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .underflow(underflow), .exception(exception)
    );

    fp_mul_round_stage #(.XLEN(32), .EXP_BIAS(127), .ROUND_EN(1'b0)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
        .in_sign(in_sign), .in_exp_sum(in_exp_sum), .in_mant_prod(in_mant_prod),
        .in_a_class(in_a_class), .in_b_class(in_b_class),
        .out_valid(out_valid_t), .out_ready(out_ready), .result(result_t),
        .overflow(overflow_t), .underflow(underflow_t), .exception(exception_t)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        exc;
    } exp_t;

    typedef struct {
        string       name;
        logic        sign;
        logic [8:0]  es;
        logic [47:0] prod;
        logic [1:0]  ca;
        logic [1:0]  cb;
        exp_t        r;
        exp_t        t;
    } vec_t;

    exp_t q_r[$];
    exp_t q_t[$];
    vec_t vecs[$];
    bit   acc, got;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic chk_out(string name, exp_t e, logic [31:0] r, logic o, logic u, logic x);
        chk({name, ".result"}, 64'(r), 64'(e.res));
        chk({name, ".flags"}, 64'({o, u, x}), 64'({e.ovf, e.unf, e.exc}));
    endtask

    // Reference: rounding decided by comparing the discarded remainder against one half.
    function automatic exp_t ref_model(logic s, logic [8:0] es, logic [47:0] p,
                                       logic [1:0] ca, logic [1:0] cb, bit rne);
        exp_t r;
        longint unsigned pu, keep, rem, half, m;
        int sh, e;
        r.res = 32'h0; r.ovf = 1'b0; r.unf = 1'b0; r.exc = 1'b0;
        if (ca == 2'b11 || cb == 2'b11 || (ca == 2'b10 && cb == 2'b01) ||
            (ca == 2'b01 && cb == 2'b10)) begin
            r.res = 32'h7FC00000;
            r.exc = 1'b1;
        end else if (ca == 2'b10 || cb == 2'b10) begin
            r.res = {s, 8'hFF, 23'h0};
        end else if (ca == 2'b01 || cb == 2'b01) begin
            r.res = {s, 31'h0};
        end else begin
            sh   = p[47] ? 24 : 23;
            pu   = 64'(p);
            keep = (pu >> sh) % (64'd1 << 23);
            rem  = pu % (64'd1 << sh);
            half = 64'd1 << (sh - 1);
            e    = int'(es) - 127 + (p[47] ? 1 : 0);
            if (e <= 0) begin
                r.res = {s, 31'h0};
                r.unf = 1'b1;
            end else begin
                m = keep;
                if (rne && (rem > half || (rem == half && keep[0]))) m++;
                if (m == (64'd1 << 23)) begin
                    m = 0;
                    e++;
                end
                if (e >= 255) begin
                    r.res = {s, 8'hFF, 23'h0};
                    r.ovf = 1'b1;
                end else begin
                    r.res = {s, 8'(e), 23'(m)};
                end
            end
        end
        return r;
    endfunction

    function automatic vec_t mkv(string n, logic s, logic [8:0] es, logic [47:0] p,
                                 logic [1:0] ca, logic [1:0] cb,
                                 logic [31:0] rr, logic [2:0] rf,
                                 logic [31:0] tr, logic [2:0] tf);
        vec_t v;
        v.name = n; v.sign = s; v.es = es; v.prod = p; v.ca = ca; v.cb = cb;
        v.r.res = rr; v.r.ovf = rf[2]; v.r.unf = rf[1]; v.r.exc = rf[0];
        v.t.res = tr; v.t.ovf = tf[2]; v.t.unf = tf[1]; v.t.exc = tf[0];
        return v;
    endfunction

    task automatic drive(logic s, logic [8:0] es, logic [47:0] p, logic [1:0] ca, logic [1:0] cb);
        in_sign = s; in_exp_sum = es; in_mant_prod = p; in_a_class = ca; in_b_class = cb;
    endtask

    // Called at a falling edge with inputs already driven; scores the coming rising edge.
    task automatic step();
        exp_t e;
        #1;
        acc = in_valid && in_ready;
        got = out_valid && out_ready;
        if (got) begin
            if (q_r.size() == 0) begin
                checks++; failures++;
                $display("FAIL spurious_out: got %0h expected no result", result);
            end else begin
                e = q_r.pop_front();
                chk_out("sb_rne", e, result, overflow, underflow, exception);
            end
        end
        if (out_valid_t && out_ready) begin
            if (q_t.size() == 0) begin
                checks++; failures++;
                $display("FAIL spurious_out_trunc: got %0h expected no result", result_t);
            end else begin
                e = q_t.pop_front();
                chk_out("sb_trunc", e, result_t, overflow_t, underflow_t, exception_t);
            end
        end
        if (acc) begin
            q_r.push_back(ref_model(in_sign, in_exp_sum, in_mant_prod, in_a_class, in_b_class, 1'b1));
            q_t.push_back(ref_model(in_sign, in_exp_sum, in_mant_prod, in_a_class, in_b_class, 1'b0));
        end
        @(negedge clk);
    endtask

    task automatic rand_beat();
        logic [47:0] p;
        p = {16'($urandom), $urandom};
        if (p[47:46] == 2'b00) p[46] = 1'b1;
        if ($urandom_range(0, 3) == 0) p[22:0] = {p[22], 22'h0};
        in_sign      = 1'($urandom);
        in_exp_sum   = ($urandom_range(0, 2) == 0) ? 9'($urandom_range(120, 135))
                     : ($urandom_range(0, 1) == 0) ? 9'($urandom_range(375, 390))
                     : 9'($urandom_range(0, 510));
        in_mant_prod = p;
        in_a_class   = ($urandom_range(0, 7) < 6) ? 2'b00 : 2'($urandom);
        in_b_class   = ($urandom_range(0, 7) < 6) ? 2'b00 : 2'($urandom);
    endtask

    logic [47:0] bp_prod [4];
    int idx, n_out, first_c, last_c;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(1'b0, 9'd0, 48'h0, 2'b00, 2'b00);
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.result", 64'(result), 64'd0);
        chk("rst.flags", 64'({overflow, underflow, exception}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // name, sign, exp_sum, prod, ca, cb, rne result/flags{ovf,unf,exc}, trunc result/flags
        vecs.push_back(mkv("basic",      0, 254, 48'h9000_0000_0000, 0, 0, 32'h40100000, 3'b000, 32'h40100000, 3'b000));
        vecs.push_back(mkv("tie_up",     0, 254, 48'h4000_00C0_0000, 0, 0, 32'h3F800002, 3'b000, 32'h3F800001, 3'b000));
        vecs.push_back(mkv("tie_even",   0, 254, 48'h4000_0040_0000, 0, 0, 32'h3F800000, 3'b000, 32'h3F800000, 3'b000));
        vecs.push_back(mkv("above_half", 0, 254, 48'h4000_0060_0000, 0, 0, 32'h3F800001, 3'b000, 32'h3F800000, 3'b000));
        vecs.push_back(mkv("rnd_carry",  0, 254, 48'h7FFF_FFFF_FFFF, 0, 0, 32'h40000000, 3'b000, 32'h3FFFFFFF, 3'b000));
        vecs.push_back(mkv("ovf",        1, 400, 48'h4000_0000_0000, 0, 0, 32'hFF800000, 3'b100, 32'hFF800000, 3'b100));
        vecs.push_back(mkv("unf",        0, 100, 48'h4000_0000_0000, 0, 0, 32'h00000000, 3'b010, 32'h00000000, 3'b010));
        vecs.push_back(mkv("e_254",      0, 381, 48'h4000_0000_0000, 0, 0, 32'h7F000000, 3'b000, 32'h7F000000, 3'b000));
        vecs.push_back(mkv("e_255",      0, 382, 48'h4000_0000_0000, 0, 0, 32'h7F800000, 3'b100, 32'h7F800000, 3'b100));
        vecs.push_back(mkv("carry_ovf",  0, 381, 48'h7FFF_FFFF_FFFF, 0, 0, 32'h7F800000, 3'b100, 32'h7F7FFFFF, 3'b000));
        vecs.push_back(mkv("e_0",        0, 127, 48'h4000_0000_0000, 0, 0, 32'h00000000, 3'b010, 32'h00000000, 3'b010));
        vecs.push_back(mkv("e_1_norm",   0, 127, 48'h8000_0000_0000, 0, 0, 32'h00800000, 3'b000, 32'h00800000, 3'b000));
        vecs.push_back(mkv("inf_zero",   0, 254, 48'h4000_0000_0000, 2, 1, 32'h7FC00000, 3'b001, 32'h7FC00000, 3'b001));
        vecs.push_back(mkv("inf_norm",   1, 254, 48'h4000_0000_0000, 2, 0, 32'hFF800000, 3'b000, 32'hFF800000, 3'b000));
        vecs.push_back(mkv("zero_norm",  1, 254, 48'h4000_0000_0000, 1, 0, 32'h80000000, 3'b000, 32'h80000000, 3'b000));
        vecs.push_back(mkv("nan_b",      1, 254, 48'h4000_0000_0000, 0, 3, 32'h7FC00000, 3'b001, 32'h7FC00000, 3'b001));
        vecs.push_back(mkv("zero_nan",   0, 254, 48'h4000_0000_0000, 1, 3, 32'h7FC00000, 3'b001, 32'h7FC00000, 3'b001));

        // Directed table: one beat in, check 1-cycle gap then result on cycle 2.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].sign, vecs[i].es, vecs[i].prod, vecs[i].ca, vecs[i].cb);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk({vecs[i].name, ".lat1_valid"}, 64'(out_valid), 64'd0);
            @(negedge clk);
            chk({vecs[i].name, ".lat2_valid"}, 64'(out_valid), 64'd1);
            chk_out({vecs[i].name, ".rne"}, vecs[i].r, result, overflow, underflow, exception);
            chk_out({vecs[i].name, ".trunc"}, vecs[i].t, result_t, overflow_t, underflow_t, exception_t);
        end
        @(negedge clk);

        // Backpressure: four beats against a stalled consumer.
        bp_prod[0] = 48'h9000_0000_0000; bp_prod[1] = 48'h4000_00C0_0000;
        bp_prod[2] = 48'hC000_0000_0000; bp_prod[3] = 48'h7FFF_FFFF_FFFF;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4);
            drive(1'b0, 9'd254, bp_prod[idx % 4], 2'b00, 2'b00);
            step();
            if (acc) idx++;
        end
        chk("bp.accepted", 64'(idx), 64'd2);
        #1;
        chk("bp.in_ready_low", 64'(in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            chk("bp.held_valid", 64'(out_valid), 64'd1);
            if (q_r.size() > 0) chk_out("bp.held", q_r[0], result, overflow, underflow, exception);
            @(negedge clk);
        end
        out_ready = 1'b1;
        n_out = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (idx < 4);
            drive(1'b0, 9'd254, bp_prod[idx % 4], 2'b00, 2'b00);
            step();
            if (acc) idx++;
            if (got) begin
                n_out++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        in_valid = 1'b0;
        chk("bp.results", 64'(n_out), 64'd4);
        chk("bp.back_to_back", 64'(last_c - first_c), 64'd3);

        // Random traffic with random stalls; inputs held until accepted.
        in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || acc) begin
                rand_beat();
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        chk("drain.empty", 64'(q_r.size() + q_t.size()), 64'd0);

        // Reset with two beats in flight.
        drive(1'b1, 9'd400, 48'h4000_0000_0000, 2'b00, 2'b00);
        in_valid = 1'b1;
        step();
        drive(1'b0, 9'd254, 48'h4000_0000_0000, 2'b11, 2'b00);
        step();
        in_valid = 1'b0;
        chk("rstmid.pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rstmid.out_valid", 64'(out_valid), 64'd0);
        chk("rstmid.flags", 64'({overflow, underflow, exception}), 64'd0);
        chk("rstmid.result", 64'(result), 64'd0);
        chk("rstmid.in_ready", 64'(in_ready), 64'd1);
        q_r.delete();
        q_t.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("rstmid.no_stale", 64'(out_valid | out_valid_t), 64'd0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
